store_data_aligner: RTL and testbench
=====================================

// Module: store_data_aligner
// PURPOSE
//  Store-side counterpart of the load-data sign/zero-extension path. Takes a store request
//  (address, register data, funct3 size) from the memory stage and aligns the data onto
//  byte lanes with a byte-strobe for the 32-bit data-memory port. Splits word-crossing
//  stores into two bus beats, uses a valid/ready handshake on both sides, and flags illegal stores.
// PARAMETERS
//  size    32   data/bus width in bits; only 32 is supported (4 byte lanes)
//  ADDR_W  32   address width
// PORTS
//  clk        in   1       clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  req_valid  in   1       store request valid
//  req_ready  out  1       request accepted when req_valid & req_ready
//  req_addr   in   ADDR_W  byte address
//  req_data   in   size    rs2 data, right-justified
//  req_type   in   3       funct3: [1:0] 00=SB 01=SH 10=SW 11=illegal; [2] ignored
//  mem_valid  out  1       bus beat valid
//  mem_ready  in   1       bus beat accepted when mem_valid & mem_ready
//  mem_addr   out  ADDR_W  word-aligned beat address ([1:0]=00)
//  mem_wdata  out  size    lane-aligned write data; unused lanes driven 0
//  mem_wstrb  out  size/8  byte strobe, bit i = byte lane i
//  done       out  1       1-cycle pulse: store fully written
//  err        out  1       1-cycle pulse: store rejected, no bus access
// BEHAVIOUR
//  - Reset (async): state=IDLE; mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err = 0.
//  - req_ready = (state==IDLE), combinational; high during and right after reset.
//  - FSM IDLE/BEAT0/BEAT1. n = 1/2/4 bytes from req_type[1:0]; off = req_addr[1:0];
//    cross = (off+n > 4).
//  - IDLE, on accept: latch addr/data/type. type 11 -> err pulse next cycle, stay IDLE.
//    Otherwise -> BEAT0.
//  - BEAT0 (registered outputs, valid first in the cycle after accept):
//    mem_addr = {addr[ADDR_W-1:2],2'b00}; mem_wdata = data << 8*off (truncated to size);
//    mem_wstrb = (((1<<n)-1) << off)[3:0].
//  - BEAT0 handshake: if cross -> BEAT1; else -> IDLE, with done pulsed next cycle.
//  - BEAT1: mem_addr = BEAT0 addr + 4, modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000);
//    mem_wdata = data >> 8*(4-off); mem_wstrb = ((1<<n)-1) >> (4-off).
//    Handshake -> IDLE, done pulsed next cycle.
//  - While mem_valid & !mem_ready: mem_addr/wdata/wstrb held stable. mem_valid never drops
//    before its handshake.
//  - done and req_ready high in the same cycle, so the next request can be accepted that cycle.
//  - One done per accepted legal store; none for an err store.
//  - Reset mid-transaction: beat abandoned, mem_valid low immediately, no done/err.
// CONFIGURATION
//  MISALIGNED_SPLIT_EN defined: cross stores are split into BEAT0+BEAT1 as above.
//  MISALIGNED_SPLIT_EN undefined: a cross store pulses err the cycle after accept, issues no
//    beat, and stays IDLE. Misaligned but non-crossing stores (e.g. SH at off=1) are legal
//    in both builds.
// TESTING
//  1. SB addr 0x1003 data 0xA5
//     -> 1 beat: addr 0x1000, wdata 0xA5000000, wstrb 1000; done once.
//  2. SH addr 0x2002 data 0x1234BEEF
//     -> addr 0x2000, wdata 0xBEEF0000, wstrb 1100; done.
//  3. SW addr 0x3001 data 0x11223344, split on
//     -> beat0: 0x3000, 0x22334400, 1110; beat1: 0x3004, 0x00000011, 0001; single done.
//     Split off -> err pulse, mem_valid stays 0.
//  4. SW addr 0x4000 with mem_ready low for 5 cycles
//     -> mem_* stable, req_ready 0; done 1 cycle after ready.
//  5. req_type 011 -> err pulse, no beat.
//     SH addr 0xFFFFFFFF (split on) -> beat1 addr 0x00000000, wstrb 0001.
//  6. reset_n low during beat1 of test 3
//     -> mem_valid 0 at once, no done; after release SB 0x0 is accepted and completes normally.

Source files
------------

// File: rtl/store_data_aligner.sv
// Store data aligner: lane-aligns store data and byte strobes onto a 32-bit bus.
// Build option MISALIGNED_SPLIT_EN: split word-crossing stores into two beats.
module store_data_aligner #(
  parameter int size   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [size-1:0]   req_data,
  input  logic [2:0]        req_type,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [size-1:0]   mem_wdata,
  output logic [size/8-1:0] mem_wstrb,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]        req_off;
  logic [2:0]        req_n;
  logic [3:0]        req_mask;
  logic [size-1:0]   req_bmask;
  logic [size-1:0]   req_dm;
  logic              req_cross;
  logic              req_bad;
  logic              type_unused;

  logic [7:0]        strb0_wide;
  logic [ADDR_W-1:0] b0_addr;
  logic [size-1:0]   b0_data;
  logic [3:0]        b0_strb;

  logic [size-1:0]   data_q;
  logic [1:0]        off_q;
  logic [3:0]        mask_q;
  logic              cross_q;

  logic [5:0]        b1_sh;
  logic [2:0]        b1_lsh;
  logic [ADDR_W-1:0] b1_addr;
  logic [size-1:0]   b1_data;
  logic [3:0]        b1_strb;

  logic              valid_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [size-1:0]   wdata_nx;
  logic [3:0]        wstrb_nx;
  logic              done_nx;
  logic              err_nx;
  logic              latch;

  assign req_off     = req_addr[1:0];
  assign type_unused = req_type[2];
  assign req_ready   = (state == IDLE);

  always_comb begin
    req_n    = 3'd0;
    req_mask = 4'b0000;
    unique case (req_type[1:0])
      2'b00: begin
        req_n    = 3'd1;
        req_mask = 4'b0001;
      end
      2'b01: begin
        req_n    = 3'd2;
        req_mask = 4'b0011;
      end
      2'b10: begin
        req_n    = 3'd4;
        req_mask = 4'b1111;
      end
      default: begin
        req_n    = 3'd0;
        req_mask = 4'b0000;
      end
    endcase
  end

  // Bytes above the access size are cleared so unused lanes stay 0.
  assign req_bmask = {{8{req_mask[3]}}, {8{req_mask[2]}},
                      {8{req_mask[1]}}, {8{req_mask[0]}}};
  assign req_dm    = req_data & req_bmask;
  assign req_cross = ({1'b0, req_off} + req_n) > 3'd4;

`ifdef MISALIGNED_SPLIT_EN
  assign req_bad = (req_type[1:0] == 2'b11);
`else
  assign req_bad = (req_type[1:0] == 2'b11) | req_cross;
`endif

  assign strb0_wide = {4'b0000, req_mask} << req_off;
  assign b0_strb    = strb0_wide[3:0];
  assign b0_addr    = {req_addr[ADDR_W-1:2], 2'b00};
  assign b0_data    = req_dm << {req_off, 3'b000};

  // Second beat carries the bytes shifted out of the top of beat 0.
  assign b1_sh   = 6'd32 - {1'b0, off_q, 3'b000};
  assign b1_lsh  = 3'd4 - {1'b0, off_q};
  assign b1_addr = mem_addr + ADDR_W'(4);
  assign b1_data = data_q >> b1_sh;
  assign b1_strb = mask_q >> b1_lsh;

  always_comb begin
    state_nx = state;
    valid_nx = mem_valid;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    wstrb_nx = mem_wstrb;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          latch = 1'b1;
          if (req_bad) begin
            err_nx = 1'b1;
          end else begin
            state_nx = BEAT0;
            valid_nx = 1'b1;
            addr_nx  = b0_addr;
            wdata_nx = b0_data;
            wstrb_nx = b0_strb;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (cross_q) begin
            state_nx = BEAT1;
            addr_nx  = b1_addr;
            wdata_nx = b1_data;
            wstrb_nx = b1_strb;
          end else begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            done_nx  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      data_q    <= '0;
      off_q     <= 2'b00;
      mask_q    <= 4'b0000;
      cross_q   <= 1'b0;
    end else begin
      mem_valid <= valid_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      mem_wstrb <= wstrb_nx;
      done      <= done_nx;
      err       <= err_nx;
      if (latch) begin
        data_q  <= req_dm;
        off_q   <= req_off;
        mask_q  <= req_mask;
        cross_q <= req_cross;
      end
    end
  end

endmodule

// File: tb/tb_store_data_aligner.sv
// Randomized self-checking bench for store_data_aligner.
// Byte-level reference model; honours MISALIGNED_SPLIT_EN.
module tb_store_data_aligner;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_type = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  store_data_aligner #(.size(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_type  (req_type),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err       (err)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Each store byte i lands at byte address a+i: word (a+i)&~3, lane (a+i)&3.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, output int nb,
                       output logic [1:0][67:0] bt, output bit e);
    int n;
    int idx;
    logic [31:0] ba;
    logic [31:0] w0;
    n  = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
    e  = (t[1:0] == 2'd3);
    if (!e && !SPLIT && (int'(a[1:0]) + n > 4)) e = 1'b1;
    nb = 0;
    bt = '0;
    w0 = a & ~32'd3;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        ba  = a + 32'(i);
        idx = ((ba & ~32'd3) == w0) ? 0 : 1;
        if (idx + 1 > nb) nb = idx + 1;
        bt[idx][67:36] = ba & ~32'd3;
        bt[idx][4 + 8*int'(ba[1:0]) +: 8] = d[8*i +: 8];
        bt[idx][int'(ba[1:0])] = 1'b1;
      end
    end
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] t, input int pct,
                           input bit linger, output int nb,
                           output logic [1:0][67:0] bt, output int nd,
                           output int ne, output int unst, output bit tmo);
    logic [67:0] cur;
    logic [67:0] prev;
    bit stall;
    int left;
    int k;
    nb = 0; bt = '0; nd = 0; ne = 0; unst = 0; tmo = 1'b0;
    stall = 1'b0; prev = '0; left = -1; k = 0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_type = t;
    mem_ready = 1'b0;
    while (!req_ready && k < 50) begin
      tick;
      k++;
    end
    if (!req_ready) tmo = 1'b1;
    tick;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_type  = 3'($urandom_range(7));
    for (int c = 0; c < 300; c++) begin
      if (done) nd++;
      if (err) ne++;
      if ((done || err) && left < 0) left = linger ? 3 : 0;
      if (left == 0) break;
      if (left > 0) left--;
      cur = {mem_addr, mem_wdata, mem_wstrb};
      if (stall && (!mem_valid || cur !== prev)) unst++;
      mem_ready = ($urandom_range(99) < pct);
      if (mem_valid && mem_ready) begin
        if (nb < 2) bt[nb] = cur;
        nb++;
      end
      stall = mem_valid && !mem_ready;
      prev  = cur;
      tick;
    end
    if (left < 0) tmo = 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    checks++;
    if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err} !== 71'd0)
      $display("FAIL reset_outputs: got %h, want 0",
               {mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err});
    else passed++;
    checks++;
    if (req_ready !== 1'b1)
      $display("FAIL reset_ready: got %b, want 1", req_ready);
    else passed++;
    tick;
    reset_n = 1'b1;
    tick;
    checks++;
    if ({req_ready, mem_valid, done, err} !== 4'b1000)
      $display("FAIL post_reset_idle: got %b, want 1000",
               {req_ready, mem_valid, done, err});
    else passed++;
  endtask

  task automatic test_directed;
    logic [31:0] ta [6] = '{32'h1003, 32'h2002, 32'h3001,
                            32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0101};
    logic [31:0] td [6] = '{32'h0000_00A5, 32'h1234_BEEF, 32'h1122_3344,
                            32'h5555_AAAA, 32'h0000_CAFE, 32'hDEAD_BEEF};
    logic [2:0]  tt [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b001};
    int nb, enb, nd, ne, unst;
    bit tmo, e;
    logic [1:0][67:0] bt, ebt;
    for (int i = 0; i < 6; i++) begin
      model(ta[i], td[i], tt[i], enb, ebt, e);
      run_store(ta[i], td[i], tt[i], 60, 1'b1, nb, bt, nd, ne, unst, tmo);
      checks++;
      if ({32'(nb), bt} !== {32'(enb), ebt})
        $display("FAIL dir%0d_beats: got n=%0d %h, want n=%0d %h",
                 i, nb, bt, enb, ebt);
      else passed++;
      checks++;
      if ({nd, ne} !== {(e ? 0 : 1), (e ? 1 : 0)})
        $display("FAIL dir%0d_pulses: got done=%0d err=%0d, want %0d %0d",
                 i, nd, ne, e ? 0 : 1, e ? 1 : 0);
      else passed++;
      checks++;
      if ({unst, tmo} !== 33'd0)
        $display("FAIL dir%0d_handshake: got unstable=%0d tmo=%b, want 0 0",
                 i, unst, tmo);
      else passed++;
    end
  endtask

  task automatic test_stall;
    logic [31:0] d;
    int enb;
    bit e;
    logic [1:0][67:0] ebt;
    d = $urandom;
    model(32'h4000, d, 3'b010, enb, ebt, e);
    req_valid = 1'b1; req_addr = 32'h4000; req_data = d; req_type = 3'b010;
    tick;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_valid, req_ready, mem_addr, mem_wdata, mem_wstrb} !==
          {2'b10, ebt[0]})
        $display("FAIL stall%0d: got %b%b %h, want 10 %h",
                 i, mem_valid, req_ready,
                 {mem_addr, mem_wdata, mem_wstrb}, ebt[0]);
      else passed++;
      tick;
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    checks++;
    if ({done, req_ready, mem_valid} !== 3'b110)
      $display("FAIL stall_done: got %b, want 110", {done, req_ready, mem_valid});
    else passed++;
    tick;
    checks++;
    if (done !== 1'b0)
      $display("FAIL stall_done_width: got %b, want 0", done);
    else passed++;
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    logic [2:0] t;
    int r, nb, enb, nd, ne, unst, bad;
    bit tmo, e;
    logic [1:0][67:0] bt, ebt;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(3));
      d = $urandom;
      r = $urandom_range(9);
      t = {1'($urandom_range(1)),
           (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3};
      model(a, d, t, enb, ebt, e);
      run_store(a, d, t, $urandom_range(100, 20), 1'b1,
                nb, bt, nd, ne, unst, tmo);
      checks++;
      if ({32'(nb), bt, nd, ne, unst, tmo} !==
          {32'(enb), ebt, (e ? 0 : 1), (e ? 1 : 0), 32'd0, 1'b0}) begin
        $display("FAIL rand%0d a=%h d=%h t=%b: got n=%0d %h d%0d e%0d u%0d t%b, want n=%0d %h d%0d e%0d",
                 i, a, d, t, nb, bt, nd, ne, unst, tmo,
                 enb, ebt, e ? 0 : 1, e ? 1 : 0);
        bad++;
      end else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    logic [2:0] t;
    int nb, enb, nd, ne, unst;
    bit tmo, e;
    logic [1:0][67:0] bt, ebt;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      d = $urandom;
      t = 3'($urandom_range(2));
      model(a, d, t, enb, ebt, e);
      run_store(a, d, t, (i < 5) ? 100 : 50, 1'b0,
                nb, bt, nd, ne, unst, tmo);
      checks++;
      if ({32'(nb), bt, nd, ne, unst, tmo} !==
          {32'(enb), ebt, (e ? 0 : 1), (e ? 1 : 0), 32'd0, 1'b0})
        $display("FAIL b2b%0d: got n=%0d %h d%0d e%0d u%0d t%b, want n=%0d %h",
                 i, nb, bt, nd, ne, unst, tmo, enb, ebt);
      else passed++;
    end
    tick;
    checks++;
    if ({done, err, mem_valid, req_ready} !== 4'b0001)
      $display("FAIL b2b_quiet: got %b, want 0001",
               {done, err, mem_valid, req_ready});
    else passed++;
  endtask

  task automatic test_reset_mid;
    int nb, enb, nd, ne, unst;
    bit tmo, e;
    logic [1:0][67:0] bt, ebt;
    logic [31:0] want_addr;
    logic [31:0] d;
    req_valid = 1'b1;
    req_type  = 3'b010;
    if (SPLIT) begin
      req_addr = 32'h3001; req_data = 32'h1122_3344;
      tick;
      req_valid = 1'b0;
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      want_addr = 32'h3004;
    end else begin
      req_addr = 32'h4000; req_data = 32'h1122_3344;
      tick;
      req_valid = 1'b0;
      mem_ready = 1'b0;
      want_addr = 32'h4000;
    end
    checks++;
    if ({mem_valid, mem_addr} !== {1'b1, want_addr})
      $display("FAIL mid_beat: got %b %h, want 1 %h",
               mem_valid, mem_addr, want_addr);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0)
      $display("FAIL mid_async_drop: got %b, want 0", mem_valid);
    else passed++;
    tick;
    tick;
    checks++;
    if ({done, err, mem_valid, req_ready} !== 4'b0001)
      $display("FAIL mid_in_reset: got %b, want 0001",
               {done, err, mem_valid, req_ready});
    else passed++;
    reset_n = 1'b1;
    tick;
    checks++;
    if ({done, err, mem_valid} !== 3'b000)
      $display("FAIL mid_after_release: got %b, want 000",
               {done, err, mem_valid});
    else passed++;
    d = $urandom;
    model(32'h0, d, 3'b000, enb, ebt, e);
    run_store(32'h0, d, 3'b000, 70, 1'b1, nb, bt, nd, ne, unst, tmo);
    checks++;
    if ({32'(nb), bt, nd, ne, unst, tmo} !==
        {32'(enb), ebt, 32'd1, 32'd0, 32'd0, 1'b0})
      $display("FAIL mid_recover: got n=%0d %h d%0d e%0d u%0d t%b, want n=%0d %h d1 e0",
               nb, bt, nd, ne, unst, tmo, enb, ebt);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_stall;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
